// File: rtl/triangle_scan_ctrl_if.sv
// rtl/triangle_scan_ctrl_if.sv - point/pixel handshake bundle for the triangle scan controller
//
// Purpose: groups the two handshakes leaving the scan controller.
//   tp_*  : point request to the triangle test unit (req held until ack).
//   pix_* : inside-pixel stream to the downstream sink (valid held until ready).
// Modports:
//   master : scan controller side (drives tp_x/tp_y/tp_req, pix_x/pix_y/pix_valid)
//   slave  : triangle unit + pixel sink side (drives tp_ack/tp_inside, pix_ready)
// Parameters: XW x coordinate width, YW y coordinate width.

interface triangle_scan_ctrl_if #(
  parameter int XW = 11,
  parameter int YW = 10
);
  logic [XW-1:0] tp_x;
  logic [YW-1:0] tp_y;
  logic          tp_req;
  logic          tp_ack;
  logic          tp_inside;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          pix_valid;
  logic          pix_ready;

  modport master (
    output tp_x, tp_y, tp_req, pix_x, pix_y, pix_valid,
    input  tp_ack, tp_inside, pix_ready
  );

  modport slave (
    input  tp_x, tp_y, tp_req, pix_x, pix_y, pix_valid,
    output tp_ack, tp_inside, pix_ready
  );
endinterface

// File: rtl/triangle_scan_ctrl.sv
// rtl/triangle_scan_ctrl.sv - bounding-box raster sequencer for the point-in-triangle unit
//
// Purpose: latches three vertices on set, computes their bounding box, walks
// every pixel of the box in raster order issuing each point to the triangle
// unit, forwards pixels reported inside to the sink and counts them.
// Optional feature macro: TRI_DEGEN_SKIP_EN (zero-area triangles skip the scan).
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   set               : start strobe, honoured only in IDLE
//   ax/ay bx/by cx/cy : vertex coordinates, sampled in the set cycle
//   bus (master)      : tp_* point handshake and pix_* inside-pixel stream
//   busy              : high in every state except IDLE
//   done              : one-cycle pulse at end of scan
//   count             : inside pixels of the current/last scan

module triangle_scan_ctrl #(
  parameter int XW = 11,
  parameter int YW = 10,
  parameter int CW = 22
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          set,
  input  logic [XW-1:0] ax,
  input  logic [YW-1:0] ay,
  input  logic [XW-1:0] bx,
  input  logic [YW-1:0] by,
  input  logic [XW-1:0] cx,
  input  logic [YW-1:0] cy,
  triangle_scan_ctrl_if.master bus,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BBOX  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_EMIT  = 3'd4,
    S_NEXT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  state_t        state_q, state_d;
  logic [XW-1:0] ax_q, ax_d, bx_q, bx_d, cx_q, cx_d;
  logic [YW-1:0] ay_q, ay_d, by_q, by_d, cy_q, cy_d;
  logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic [CW-1:0] count_q, count_d;

  // Bounding box of the registered vertices, consumed in BBOX.
  logic [XW-1:0] bb_xmin, bb_xmax;
  logic [YW-1:0] bb_ymin, bb_ymax;

  function automatic logic [XW-1:0] min3_x(input logic [XW-1:0] a, b, c);
    logic [XW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [XW-1:0] max3_x(input logic [XW-1:0] a, b, c);
    logic [XW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [YW-1:0] min3_y(input logic [YW-1:0] a, b, c);
    logic [YW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [YW-1:0] max3_y(input logic [YW-1:0] a, b, c);
    logic [YW-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  always_comb begin
    bb_xmin = min3_x(ax_q, bx_q, cx_q);
    bb_xmax = max3_x(ax_q, bx_q, cx_q);
    bb_ymin = min3_y(ay_q, by_q, cy_q);
    bb_ymax = max3_y(ay_q, by_q, cy_q);
  end

`ifdef TRI_DEGEN_SKIP_EN
  // Twice the signed triangle area. Coordinates are zero-extended into a
  // signed word wide enough that neither product nor difference overflows.
  localparam int AW = XW + YW + 3;
  logic signed [AW-1:0] ax_s, ay_s, bx_s, by_s, cx_s, cy_s;
  logic signed [AW-1:0] area;
  logic                 degen;

  always_comb begin
    ax_s  = signed'({{(AW-XW){1'b0}}, ax_q});
    bx_s  = signed'({{(AW-XW){1'b0}}, bx_q});
    cx_s  = signed'({{(AW-XW){1'b0}}, cx_q});
    ay_s  = signed'({{(AW-YW){1'b0}}, ay_q});
    by_s  = signed'({{(AW-YW){1'b0}}, by_q});
    cy_s  = signed'({{(AW-YW){1'b0}}, cy_q});
    area  = (bx_s - ax_s) * (cy_s - ay_s) - (by_s - ay_s) * (cx_s - ax_s);
    degen = (area == '0);
  end
`else
  logic degen;
  assign degen = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    bx_d    = bx_q;
    by_d    = by_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    xmin_d  = xmin_q;
    xmax_d  = xmax_q;
    ymin_d  = ymin_q;
    ymax_d  = ymax_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    pix_x_d = pix_x_q;
    pix_y_d = pix_y_q;
    count_d = count_q;

    case (state_q)
      S_IDLE: begin
        if (set) begin
          ax_d    = ax;
          ay_d    = ay;
          bx_d    = bx;
          by_d    = by;
          cx_d    = cx;
          cy_d    = cy;
          count_d = '0;
          state_d = S_BBOX;
        end
      end

      S_BBOX: begin
        xmin_d  = bb_xmin;
        xmax_d  = bb_xmax;
        ymin_d  = bb_ymin;
        ymax_d  = bb_ymax;
        cur_x_d = bb_xmin;
        cur_y_d = bb_ymin;
        state_d = degen ? S_DONE : S_ISSUE;
      end

      // ISSUE is the first request cycle; a zero-wait unit may ack here, so
      // it shares the ack handling with WAIT.
      S_ISSUE, S_WAIT: begin
        if (bus.tp_ack) begin
          if (bus.tp_inside) begin
            count_d = count_q + C_ONE;
            pix_x_d = cur_x_q;
            pix_y_d = cur_y_q;
            state_d = S_EMIT;
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          state_d = S_WAIT;
        end
      end

      S_EMIT: begin
        if (bus.pix_ready) begin
          state_d = S_NEXT;
        end
      end

      // Compare against the box edge before stepping so the walk never
      // increments past xmax/ymax (no wrap at the screen edge).
      S_NEXT: begin
        state_d = S_ISSUE;
        if (cur_x_q == xmax_q) begin
          if (cur_y_q == ymax_q) begin
            state_d = S_DONE;
          end else begin
            cur_x_d = xmin_q;
            cur_y_d = cur_y_q + Y_ONE;
          end
        end else begin
          cur_x_d = cur_x_q + X_ONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      xmin_q  <= xmin_d;
      xmax_q  <= xmax_d;
      ymin_q  <= ymin_d;
      ymax_q  <= ymax_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      count_q <= count_d;
    end
  end

  // Outputs are decodes of registered state; the point on offer is always
  // the current raster position, which only moves in BBOX and NEXT.
  assign bus.tp_x      = cur_x_q;
  assign bus.tp_y      = cur_y_q;
  assign bus.tp_req    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign bus.pix_x     = pix_x_q;
  assign bus.pix_y     = pix_y_q;
  assign bus.pix_valid = (state_q == S_EMIT);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign count         = count_q;

endmodule
